// File: rtl/mem_pkg.sv
// Shared encodings for the memory arbiter: FSM states, write-size codes and the
// default MMIO window base.
package mem_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_WAIT1 = 3'd1,
      RD_WAIT2 = 3'd2,
      WR_WAIT  = 3'd3,
      VGA_WR   = 3'd4,
      RESP     = 3'd5
   } mem_state_e;

   localparam logic [1:0] WSIZE_READ = 2'b00;
   localparam logic [1:0] WSIZE_BYTE = 2'b01;
   localparam logic [1:0] WSIZE_HALF = 2'b10;
   localparam logic [1:0] WSIZE_WORD = 2'b11;

   localparam logic [31:0] MMIO_BASE_DEF = 32'h0002_0000;

   // Full-width unsigned compare; anything at or above the base is VGA text space.
   function automatic logic is_mmio(input logic [31:0] addr, input logic [31:0] base);
      return (addr >= base);
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to the
// requester that was not served last (last: 0 = core, 1 = loader).
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates core and loader accesses onto one memory port, diverting writes at
// or above MMIO_BASE to the VGA text buffer.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  IDLE     | wait for a request, arbitrate, latch addr/wsize/wdata
//  RD_WAIT1 | first memory read wait cycle
//  RD_WAIT2 | memory read data valid, captured on leaving
//  WR_WAIT  | write mode driven, wait for mem_done/mem_error or timeout
//  VGA_WR   | single-cycle write into the VGA text buffer
//  RESP     | pulse done/err to the owner, then back to IDLE
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int unsigned WORD_SIZE  = 32,
   parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEF,
   parameter int unsigned WR_TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 c_req,
   input  logic [WORD_SIZE-1:0] c_addr,
   input  logic [1:0]           c_wsize,
   input  logic [WORD_SIZE-1:0] c_wdata,
   output logic                 c_grant,
   output logic                 c_done,
   output logic                 c_err,
   output logic [WORD_SIZE-1:0] c_rdata,
   input  logic                 l_req,
   input  logic [WORD_SIZE-1:0] l_addr,
   input  logic [1:0]           l_wsize,
   input  logic [WORD_SIZE-1:0] l_wdata,
   output logic                 l_grant,
   output logic                 l_done,
   output logic                 l_err,
   output logic [WORD_SIZE-1:0] l_rdata,
   output logic [31:0]          mem_address,
   output logic [1:0]           mem_write_mode,
   output logic [31:0]          mem_write_word,
   input  logic [31:0]          mem_word_output,
   input  logic                 mem_done,
   input  logic                 mem_error,
   output logic                 vga_write_en,
   output logic [12:0]          vga_write_address,
   output logic [WORD_SIZE-1:0] vga_input_data
);

   localparam int unsigned      TMR_W    = $clog2(WR_TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(WR_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

   mem_state_e           state_q;
   logic                 owner_q;
   logic                 last_q;
   logic                 resp_err_q;
   logic [TMR_W-1:0]     tmr_q;
   logic [31:0]          mem_addr_q;
   logic [1:0]           mode_q;
   logic [31:0]          wword_q;
   logic [WORD_SIZE-1:0] wdata_q;
   logic                 c_grant_q, l_grant_q;
   logic                 c_done_q, l_done_q;
   logic                 c_err_q, l_err_q;
   logic [WORD_SIZE-1:0] c_rdata_q, l_rdata_q;
   logic                 vga_en_q;
   logic [12:0]          vga_addr_q;
   logic [WORD_SIZE-1:0] vga_data_q;

   logic [1:0]           req_vec;
   logic [1:0]           arb_grant;
   logic                 sel_l;
   logic [WORD_SIZE-1:0] sel_addr;
   logic [WORD_SIZE-1:0] sel_wdata;
   logic [1:0]           sel_wsize;
   logic                 sel_mmio;

   assign req_vec = {l_req, c_req};

   rr_arbiter2 u_rr (
      .req   (req_vec),
      .last  (last_q),
      .grant (arb_grant)
   );

   assign sel_l     = arb_grant[1];
   assign sel_addr  = sel_l ? l_addr  : c_addr;
   assign sel_wdata = sel_l ? l_wdata : c_wdata;
   assign sel_wsize = sel_l ? l_wsize : c_wsize;
   assign sel_mmio  = is_mmio(32'(sel_addr), MMIO_BASE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         last_q     <= 1'b1;
         resp_err_q <= 1'b0;
         tmr_q      <= '0;
         mem_addr_q <= '0;
         mode_q     <= WSIZE_READ;
         wword_q    <= '0;
         wdata_q    <= '0;
         c_grant_q  <= 1'b0;
         l_grant_q  <= 1'b0;
         c_done_q   <= 1'b0;
         l_done_q   <= 1'b0;
         c_err_q    <= 1'b0;
         l_err_q    <= 1'b0;
         c_rdata_q  <= '0;
         l_rdata_q  <= '0;
         vga_en_q   <= 1'b0;
         vga_addr_q <= '0;
         vga_data_q <= '0;
      end else begin
         c_grant_q <= 1'b0;
         l_grant_q <= 1'b0;
         c_done_q  <= 1'b0;
         l_done_q  <= 1'b0;
         c_err_q   <= 1'b0;
         l_err_q   <= 1'b0;
         vga_en_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (|arb_grant) begin
                  owner_q    <= sel_l;
                  last_q     <= sel_l;
                  c_grant_q  <= ~sel_l;
                  l_grant_q  <= sel_l;
                  mem_addr_q <= 32'(sel_addr);
                  wdata_q    <= sel_wdata;
                  resp_err_q <= 1'b0;
                  if (sel_wsize == WSIZE_READ) begin
                     if (sel_mmio) begin
                        // MMIO space is write-only: answer at once with an error
                        resp_err_q <= 1'b1;
                        if (sel_l) l_rdata_q <= '0;
                        else       c_rdata_q <= '0;
                        state_q <= RESP;
                     end else begin
                        state_q <= RD_WAIT1;
                     end
                  end else if (sel_mmio) begin
                     state_q <= VGA_WR;
                  end else begin
                     mode_q  <= sel_wsize;
                     wword_q <= 32'(sel_wdata);
                     tmr_q   <= TMR_LOAD;
                     state_q <= WR_WAIT;
                  end
               end
            end
            RD_WAIT1: state_q <= RD_WAIT2;
            RD_WAIT2: begin
               if (owner_q) l_rdata_q <= WORD_SIZE'(mem_word_output);
               else         c_rdata_q <= WORD_SIZE'(mem_word_output);
               state_q <= RESP;
            end
            WR_WAIT: begin
               if (mem_error || mem_done || tmr_q == '0) begin
                  // error wins over done; an expired timer also counts as error
                  resp_err_q <= mem_error || !mem_done;
                  mode_q     <= WSIZE_READ;
                  state_q    <= RESP;
               end else begin
                  tmr_q <= tmr_q - TMR_ONE;
               end
            end
            VGA_WR: begin
               vga_en_q   <= 1'b1;
               vga_addr_q <= mem_addr_q[12:0];
               vga_data_q <= wdata_q;
               state_q    <= RESP;
            end
            RESP: begin
               c_done_q <= ~owner_q;
               l_done_q <= owner_q;
               c_err_q  <= ~owner_q & resp_err_q;
               l_err_q  <= owner_q & resp_err_q;
               state_q  <= IDLE;
            end
            default: begin
               mode_q  <= WSIZE_READ;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign c_grant           = c_grant_q;
   assign l_grant           = l_grant_q;
   assign c_done            = c_done_q;
   assign l_done            = l_done_q;
   assign c_err             = c_err_q;
   assign l_err             = l_err_q;
   assign c_rdata           = c_rdata_q;
   assign l_rdata           = l_rdata_q;
   assign mem_address       = mem_addr_q;
   assign mem_write_mode    = mode_q;
   assign mem_write_word    = wword_q;
   assign vga_write_en      = vga_en_q;
   assign vga_write_address = vga_addr_q;
   assign vga_input_data    = vga_data_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, data/address width.
REQ-002 SHALL have parameter MMIO_BASE, default 32'h00020000; addresses >= MMIO_BASE go to the VGA text port.
REQ-003 SHALL have parameter WR_TIMEOUT, default 16; the maximum number of cycles to wait for mem_done.
REQ-004 SHALL have port clk, input, 1, system clock.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have, per requester r in {c (core), l (loader)}, the following ports:
- r_req, input, 1.
- r_addr, input, WORD_SIZE.
- r_wsize, input, 2; 00 read, 01 byte, 10 half, 11 word.
- r_wdata, input, WORD_SIZE.
- r_grant, output, 1.
- r_done, output, 1.
- r_err, output, 1.
- r_rdata, output, WORD_SIZE.
REQ-007 SHALL have the memory-side ports:
- mem_address, output, 32.
- mem_write_mode, output, 2.
- mem_write_word, output, 32.
- mem_word_output, input, 32.
- mem_done, input, 1.
- mem_error, input, 1.
REQ-008 SHALL have the VGA-side ports:
- vga_write_en, output, 1.
- vga_write_address, output, 13.
- vga_input_data, output, WORD_SIZE.

Function
REQ-009 SHALL implement the states IDLE, RD_WAIT1, RD_WAIT2, WR_WAIT, VGA_WR and RESP.
REQ-010 In IDLE with at least one req high, SHALL grant exactly one requester. r_grant is a one-cycle pulse. The request's addr, wsize and wdata SHALL be latched on that edge.
REQ-011 Arbitration SHALL be round-robin. On simultaneous requests, the requester not granted last SHALL win. After reset, core has priority.
REQ-012 A requester SHALL hold req and its fields stable until grant. Req deasserted before grant SHALL be ignored without error.
REQ-013 A read (wsize 00) below MMIO_BASE SHALL follow IDLE -> RD_WAIT1 -> RD_WAIT2 -> RESP. mem_word_output SHALL be sampled in RD_WAIT2, and r_rdata SHALL hold that value from RESP until the next grant to r.
REQ-014 A read at or above MMIO_BASE SHALL go to RESP with r_err=1 and r_rdata=0.
REQ-015 A write below MMIO_BASE SHALL drive mem_write_mode=wsize and mem_write_word=wdata in WR_WAIT only; mem_write_mode SHALL be 00 in every other state.
REQ-016 In WR_WAIT:
- mem_error=1 SHALL go to RESP with err=1.
- mem_done=1 SHALL go to RESP with err=0.
- Otherwise, after WR_TIMEOUT cycles in WR_WAIT, SHALL go to RESP with err=1 and mem_write_mode forced to 00.
- If mem_error and mem_done are high together, the error takes precedence.
REQ-017 A write at or above MMIO_BASE SHALL spend one cycle in VGA_WR with:
- vga_write_en=1,
- vga_write_address=addr[12:0],
- vga_input_data=wdata,
then go to RESP with err=0, independent of wsize.
REQ-018 RESP SHALL last exactly one cycle, pulse r_done (and r_err if flagged) for the granted requester only, and return to IDLE.
REQ-019 mem_address SHALL equal the latched address from the grant until the return to IDLE, and SHALL hold its last value in IDLE.
REQ-020 Latency from grant edge to done pulse SHALL be:
- 3 cycles for a read,
- 2 cycles for a VGA write,
- 2..WR_TIMEOUT+1 cycles for a memory write.
REQ-021 A new grant SHALL be issued no earlier than the cycle after RESP; there is no back-to-back grant in RESP.
REQ-022 Address arithmetic SHALL be an unsigned comparison on the full 32 bits; no wrap-around is permitted.

Reset
REQ-023 On rst low, SHALL asynchronously enter IDLE and clear the following:
- all grant/done/err outputs,
- rdata,
- mem_write_mode, mem_address, mem_write_word,
- vga_write_en, vga_write_address, vga_input_data,
- the timeout counter.
The round-robin pointer SHALL be reset to favour core.
REQ-024 Reset asserted mid-transaction SHALL abort it with no done pulse. mem_write_mode SHALL be 00 in the same cycle as reset.

Structure
REQ-025 State encodings, the wsize codes and the MMIO_BASE default SHALL live in a shared package mem_pkg, also used by the core FSM.
REQ-026 The round-robin grant logic SHALL be a separate sub-module rr_arbiter2 (inputs req[1:0], last; output grant one-hot).

Verification
REQ-027 Core reads 0x100 with memory returning 0xDEADBEEF -> c_grant at cycle 0, c_done at cycle 3, c_rdata=0xDEADBEEF, l_done never asserted.
REQ-028 Both requesters request in the same cycle twice in a row after reset -> core granted first, loader second; each receives exactly one done.
REQ-029 Loader writes a word 0x12345678 to 0x40 with mem_done returned at the 4th WR_WAIT cycle -> mem_write_mode=11 for exactly 4 cycles, then l_done=1 and l_err=0.
REQ-030 Core writes 0x41 to 0x00020010 -> vga_write_en for one cycle with vga_write_address=0x010 and vga_input_data=0x41; c_done one cycle later; mem_write_mode stays 00.
REQ-031 Core writes a byte to 0x8 with mem_done never asserted -> c_err and c_done pulse at cycle 17 (WR_TIMEOUT=16); mem_write_mode=00 afterwards.
REQ-032 rst driven low during WR_WAIT -> same-cycle mem_write_mode=00, no done pulse, and after release the arbiter is in IDLE with core priority.
